// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUOp/funct codes, internal op set,
// controller states, and the ALUOp/funct decoder.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

  function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] func);
    op_e op;
    op = OP_ILL;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_SLT: op = OP_SLT;
      default: begin
        case (func)
          FN_ADD:   op = OP_ADD;
          FN_SUB:   op = OP_SUB;
          FN_AND:   op = OP_AND;
          FN_OR:    op = OP_OR;
          FN_XOR:   op = OP_XOR;
          FN_NOR:   op = OP_NOR;
          FN_SLT:   op = OP_SLT;
          FN_SLTU:  op = OP_SLTU;
          FN_SLL:   op = OP_SLL;
          FN_SRL:   op = OP_SRL;
          FN_SRA:   op = OP_SRA;
          FN_MULTU: op = OP_MULTU;
          FN_DIVU:  op = OP_DIVU;
          FN_MFHI:  op = OP_MFHI;
          FN_MFLO:  op = OP_MFLO;
          default:  op = OP_ILL;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mdu_exec_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// done is high in the final iteration cycle; hi_out/lo_out then carry the final result.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic             r_is_div;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH-1:0] w_dif;
  logic             w_ge;

  // Multiply: r_lo holds the multiplier, shifting product bits in from the top.
  // Divide: r_lo holds the dividend, shifting quotient bits in from the bottom.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_rsh  = {r_hi, r_lo[WIDTH-1]};
    w_ge   = (w_rsh >= {1'b0, r_opd});
    w_dif  = w_rsh[WIDTH-1:0] - r_opd;
    hi_out = w_sum[WIDTH:1];
    lo_out = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      hi_out = w_ge ? w_dif : w_rsh[WIDTH-1:0];
      lo_out = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  assign done = r_busy && (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_count  <= CW'(WIDTH - 1);
      r_hi     <= '0;
      r_lo     <= is_div ? a : b;
      r_opd    <= is_div ? b : a;
    end else if (r_busy) begin
      r_hi <= hi_out;
      r_lo <= lo_out;
      if (r_count == '0) r_busy <= 1'b0;
      else               r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mdu_exec.sv
// Execute stage: ALUOp/funct decode, registered single-cycle ALU, and the
// HI/LO multiply/divide sequencer around mdu_iter.
module alu_mdu_exec
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);
  state_e r_state, w_state_nxt;
  logic             r_out_valid, r_zero, r_dbz, r_ill;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;

  op_e              w_op;
  logic             w_accept, w_b_zero, w_mdu_start, w_mdu_done, w_ill;
  logic [WIDTH-1:0] w_res, w_mdu_hi, w_mdu_lo;

  assign w_op        = decode_op(alu_op, func);
  assign in_ready    = (r_state == ST_IDLE) && !reset;
  assign w_accept    = in_valid && in_ready;
  assign w_b_zero    = (b == '0);
  assign w_mdu_start = w_accept && ((w_op == OP_MULTU) || ((w_op == OP_DIVU) && !w_b_zero));

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (w_mdu_start),
    .is_div (w_op == OP_DIVU),
    .a      (a),
    .b      (b),
    .done   (w_mdu_done),
    .hi_out (w_mdu_hi),
    .lo_out (w_mdu_lo)
  );

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (w_op)
      OP_ADD:  w_res = a + b;
      OP_SUB:  w_res = a - b;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_res = b << shamt;
      OP_SRL:  w_res = b >> shamt;
      OP_SRA:  w_res = $signed(b) >>> shamt;
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      OP_ILL:  w_ill = 1'b1;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mdu_start) w_state_nxt = (w_op == OP_MULTU) ? ST_MUL : ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (w_mdu_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Divide by zero is resolved without iterating: quotient all ones, remainder = dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_dbz       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_ill       <= 1'b0;
      if ((r_state != ST_IDLE) && w_mdu_done) begin
        r_hi        <= w_mdu_hi;
        r_lo        <= w_mdu_lo;
        r_result    <= w_mdu_lo;
        r_zero      <= (w_mdu_lo == '0);
        r_out_valid <= 1'b1;
      end else if (w_accept && (w_op == OP_DIVU) && w_b_zero) begin
        r_hi        <= a;
        r_lo        <= '1;
        r_result    <= '1;
        r_zero      <= 1'b0;
        r_dbz       <= 1'b1;
        r_out_valid <= 1'b1;
      end else if (w_accept && (w_op != OP_MULTU) && (w_op != OP_DIVU)) begin
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_ill       <= w_ill;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign illegal     = r_ill;

endmodule

// File: doc/alu_mdu_exec.md
Name: alu_mdu_exec

Overview:
Parametrised execute-stage unit for the multi-cycle MIPS datapath. It decodes ALUOp/funct internally and performs single-cycle ALU operations with one-cycle registered latency. It also performs iterative unsigned multiply/divide into HI/LO, using a valid/ready handshake. It sits between the register-read stage and write-back, and replaces the standalone ALU control decode plus combinational ALU.

Parameters:
WIDTH, 32, datapath width in bits (power of two, 8..64)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
alu_op  input  2  00 ADD, 01 SUB, 10 decode funct, 11 SLT (slti)
func  input  6  MIPS funct field
shamt  input  SHW  shift amount
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt/immediate
out_valid  output  1  one-cycle pulse: result/hi/lo final
result  output  WIDTH  operation result (registered)
zero  output  1  result == 0, registered with result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_by_zero  output  1  pulses with out_valid for divu with b==0
illegal  output  1  pulses with out_valid for an undecoded funct

Behaviour:
- Reset, synchronous, active-high: state=IDLE, count=0. out_valid, result, zero, hi, lo, div_by_zero and illegal are all 0. Reset overrides every other event, including mid multiply/divide: the operation is aborted, HI/LO are cleared and no out_valid is produced.
- Handshake: in_ready = (state==IDLE) and not reset. Accept = in_valid & in_ready. There is no output backpressure; the consumer must take out_valid when it is asserted.
- funct decode when alu_op=10:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra (all by shamt).
  - 011001 multu, 011011 divu, 010000 mfhi, 010010 mflo.
  - Any other code: result=0 and illegal=1.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; there is no overflow trap.
  - slt/sltu produce result 1 or 0, zero-extended.
- Single-cycle ops, including mfhi/mflo: accepted at edge E. At edge E+1 result, zero and flags are registered, and out_valid=1 for exactly one cycle. Back-to-back accepts are allowed every cycle.
- multu, FSM IDLE->MUL:
  - Shift-add, one bit per cycle; count runs WIDTH-1..0.
  - On the edge where count==0: {hi,lo} = a*b, state=IDLE, out_valid=1 and result=lo in the next cycle.
  - Accept at cycle 0; in_ready is low during cycles 1..WIDTH; out_valid is high in cycle WIDTH+1.
- divu, FSM IDLE->DIV:
  - Restoring division, one quotient bit per cycle, same timing as multu.
  - Outputs: lo=a/b, hi=a%b, result=lo.
- divu with b==0: no iteration. The FSM stays IDLE, lo=all ones, hi=a, and div_by_zero=1 with out_valid at E+1 (single-cycle latency).
- HI/LO change only on multu/divu completion or reset.
- mfhi/mflo return HI/LO as they stand at accept time.
- zero, div_by_zero and illegal are meaningful only while out_valid=1. In other cycles they hold their last values, except that div_by_zero and illegal return to 0 the cycle after the pulse.
- FSM states: IDLE, MUL, DIV. MUL and DIV return only to IDLE, either on count==0 or on reset.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_SLT);
  - funct code constants for every listed op;
  - internal op enum (OP_ADD..OP_MFLO, OP_ILL);
  - FSM state encoding.
- Natural sub-module: mdu_iter, the iterative unsigned multiply/divide datapath. Its interface is start, is_div, a, b, done, hi_out and lo_out. The top level keeps decode, single-cycle ALU, handshake and output registers.

Test Plan:
1. WIDTH=32, alu_op=00, a=5, b=7, accept at cycle 0 -> cycle 1: out_valid=1, result=12, zero=0; cycle 2: out_valid=0.
2. alu_op=01, a=b=9 -> result=0, zero=1. alu_op=10, func=101010, a=0xFFFFFFFF, b=1 -> result=1. Same operands with func=101011 -> result=0.
3. multu a=0x00010000, b=0x00010000 at cycle 0, with in_valid held high throughout:
   - in_ready=0 in cycles 1..32 and no second accept;
   - cycle 33: out_valid=1, hi=1, lo=0;
   - following mfhi -> result=1.
4. divu a=100, b=7 -> cycle 33: lo=14, hi=2, result=14. divu a=0x1234, b=0 -> cycle 1: out_valid=1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234.
5. multu started with reset asserted at cycle 10 -> cycle 11: in_ready=1, hi=lo=0, and out_valid stays 0 through cycle 40.
6. alu_op=10, func=111111 -> cycle 1: out_valid=1, illegal=1, result=0. Back-to-back sll (shamt=4, b=1) then sra (shamt=31, b=0x80000000) on consecutive cycles -> results 0x10, then 0xFFFFFFFF.
